// File: rtl/shift_deserializer.sv
// ---------------------------------------------------------------------------
// shift_deserializer
//
// This block is a serial-in, parallel-out receiver for the bit-serial data path.
// A one-cycle `start` strobe marks the first bit of a frame. The frame arrives
// MSB first, one bit per clock. Each complete frame goes into a single-entry
// holding register, which the consumer reads through a valid/ready handshake.
//
// Optional feature, enabled by defining the macro RX_PARITY_EN:
//   Each frame carries one extra bit after the LSB. Data plus this bit must
//   have even parity. A mismatch sets the sticky `parity_err` flag, and the
//   word is still delivered. With the macro undefined, the block has no
//   PARITY state and `parity_err` is tied to 0.
//
// Parameters:
//   DATA_WIDTH  bits per frame (2..16), default 8
//
// Ports:
//   clk         in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   din         in   serial data, MSB first
//   start       in   one-cycle strobe, coincident with the frame MSB
//   data_ready  in   consumer takes data_out when high with data_valid
//   err_clr     in   clears the sticky error flags (a same-cycle set wins)
//   data_out    out  holding register (last delivered word)
//   data_valid  out  data_out holds an unconsumed word
//   busy        out  a frame is in progress (SHIFT / PARITY / COMPLETE)
//   overrun     out  sticky, a completed frame was dropped
//   parity_err  out  sticky, parity mismatch (RX_PARITY_EN only)
// ---------------------------------------------------------------------------
module shift_deserializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  din,
    input  logic                  start,
    input  logic                  data_ready,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  busy,
    output logic                  overrun,
    output logic                  parity_err
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    // The count before the final data bit is shifted in. Reaching this value
    // in SHIFT means the current cycle samples the LSB.
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SHIFT    = 2'd1,
        S_COMPLETE = 2'd2
`ifdef RX_PARITY_EN
        ,
        S_PARITY   = 2'd3
`endif
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]      r_count;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_busy;
    logic                  r_overrun;
`ifdef RX_PARITY_EN
    logic                  r_parity_err;
`endif

    // Shift register contents after this cycle's bit is shifted in.
    logic [DATA_WIDTH-1:0] w_shift_next;
    // A new frame always starts from a clean register holding only the MSB.
    logic [DATA_WIDTH-1:0] w_shift_first;
    // Delivery is possible when the holding register is empty or is being
    // drained in this same cycle.
    logic                  w_can_load;

    assign w_shift_next  = {r_shift[DATA_WIDTH-2:0], din};
    assign w_shift_first = {{(DATA_WIDTH-1){1'b0}}, din};
    assign w_can_load    = !r_valid || data_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_count   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
`ifdef RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments are scheduled in order, so a later
            // assignment to the same register in this block overrides an
            // earlier one. The block uses this ordering for two rules: a
            // same-cycle load overrides the handshake clear of r_valid, and an
            // error set overrides err_clr.
            if (r_valid && data_ready) begin
                r_valid <= 1'b0;
            end

            if (err_clr) begin
                r_overrun <= 1'b0;
`ifdef RX_PARITY_EN
                r_parity_err <= 1'b0;
`endif
            end

            // Frame sequencing. A start strobe in any state begins a new frame.
            // In SHIFT or PARITY this silently abandons the partial frame. In
            // COMPLETE it gives back-to-back reception.
            if (start) begin
                r_shift <= w_shift_first;
                r_count <= ONE;
                r_state <= S_SHIFT;
                r_busy  <= 1'b1;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        // din is ignored until a frame starts.
                        r_busy <= 1'b0;
                    end

                    S_SHIFT: begin
                        r_shift <= w_shift_next;
                        r_count <= r_count + ONE;
                        if (r_count == LAST_BIT) begin
`ifdef RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_COMPLETE;
`endif
                        end
                    end

`ifdef RX_PARITY_EN
                    S_PARITY: begin
                        // Even parity over data plus parity bit: any odd total
                        // is a mismatch.
                        if (^{r_shift, din}) begin
                            r_parity_err <= 1'b1;
                        end
                        r_state <= S_COMPLETE;
                    end
`endif

                    S_COMPLETE: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end

                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end

            // Delivery of the assembled word. This is independent of whether
            // a new frame starts in the same cycle.
            if (r_state == S_COMPLETE) begin
                if (w_can_load) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign busy       = r_busy;
    assign overrun    = r_overrun;
`ifdef RX_PARITY_EN
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_deserializer.sv
// ---------------------------------------------------------------------------
// tb_shift_deserializer
//
// This is a self-checking bench for shift_deserializer with DATA_WIDTH=8.
// Every word the bench expects to be delivered is pushed onto a queue when its
// frame is driven. Each word the DUT hands over (data_valid & data_ready) is
// popped from the queue and compared. Directed checks cover reset, timing,
// overrun, back-to-back frames, abort, and reset in the middle of a frame.
// Defining RX_PARITY_EN adds the parity checks.
// ---------------------------------------------------------------------------
module tb_shift_deserializer;

    localparam int W = 8;
`ifdef RX_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic         din;
    logic         start;
    logic         data_ready;
    logic         err_clr;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         busy;
    logic         overrun;
    logic         parity_err;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] exp_q[$];
`ifdef RX_PARITY_EN
    logic         par_flip = 1'b0;
`endif

    always #5 clk = ~clk;

    shift_deserializer #(.DATA_WIDTH(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .din        (din),
        .start      (start),
        .data_ready (data_ready),
        .err_clr    (err_clr),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock. The scoreboard inspects the handshake on the falling edge,
    // where inputs and outputs are stable. The task then returns 1 time unit
    // after the rising edge, which is where the next inputs are driven.
    task automatic tick();
        @(negedge clk);
        if (reset_n && data_valid && data_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_word", 32'(data_valid), 32'd0);
            end else begin
                check("word", 32'(data_out), 32'(exp_q.pop_front()));
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Drives one frame, ending in the cycle that samples the last bit.
    // The next tick is the COMPLETE cycle.
    task automatic send_frame(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) begin
            start = (i == W - 1);
            din   = w[i];
            tick();
        end
`ifdef RX_PARITY_EN
        start = 1'b0;
        din   = (^w) ^ par_flip;
        tick();
`endif
        start = 1'b0;
        din   = 1'b0;
    endtask

    task automatic drain();
        data_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            tick();
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        tick();
        check("valid_after_drain", 32'(data_valid), 32'd0);
    endtask

    initial begin
        logic [W-1:0] w;

        reset_n    = 1'b0;
        din        = 1'b0;
        start      = 1'b0;
        data_ready = 1'b0;
        err_clr    = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_data_out",   32'(data_out),   32'd0);
        check("rst_valid",      32'(data_valid), 32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_overrun",    32'(overrun),    32'd0);
        check("rst_parity_err", 32'(parity_err), 32'd0);
        reset_n = 1'b1;
        tick();

        // 0xA5: busy after every sampling edge, valid only after the COMPLETE edge
        w = 8'hA5;
        exp_q.push_back(w);
        for (int k = 0; k < FRAME; k++) begin
            start = (k == 0);
            din   = (k < W) ? w[W-1-k] : ^w;
            tick();
            check("a5_busy", 32'(busy), 32'd1);
            check("a5_valid_early", 32'(data_valid), 32'd0);
        end
        start = 1'b0;
        din   = 1'b0;
        tick();
        check("a5_valid", 32'(data_valid), 32'd1);
        check("a5_data",  32'(data_out),   32'hA5);
        check("a5_busy_done", 32'(busy),   32'd0);
        drain();

        // Overrun with the consumer stalled: the first word is kept
        data_ready = 1'b0;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C);
        send_frame(8'hC3);
        tick();
        check("ovr_flag", 32'(overrun),    32'd1);
        check("ovr_data", 32'(data_out),   32'h3C);
        check("ovr_valid", 32'(data_valid), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ovr_clr", 32'(overrun), 32'd0);
        // A new overrun in the same cycle as err_clr: the set wins
        send_frame(8'h55);
        err_clr = 1'b1;
        tick();
        check("ovr_set_wins", 32'(overrun), 32'd1);
        tick();
        err_clr = 1'b0;
        check("ovr_clr2", 32'(overrun), 32'd0);
        drain();

        // Back-to-back frames, with ready raised in the second completion cycle
        data_ready = 1'b0;
        exp_q.push_back(8'h81);
        exp_q.push_back(8'h7E);
        send_frame(8'h81);
        send_frame(8'h7E);
        data_ready = 1'b1;
        tick();
        check("b2b_valid",   32'(data_valid), 32'd1);
        check("b2b_data",    32'(data_out),   32'h7E);
        check("b2b_overrun", 32'(overrun),    32'd0);
        drain();

        // Abort after 4 bits, then a full 0xF0 frame
        data_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            start = (k == 0);
            din   = k[0];
            tick();
        end
        exp_q.push_back(8'hF0);
        send_frame(8'hF0);
        repeat (4) tick();
        check("abort_q_empty", 32'(exp_q.size()), 32'd0);
        check("abort_overrun", 32'(overrun),      32'd0);
        check("abort_valid",   32'(data_valid),   32'd0);

        // Reset in the middle of a frame while a word is held: everything clears
        data_ready = 1'b0;
        send_frame(8'h99);
        tick();
        check("pre_rst_valid", 32'(data_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            start = (k == 0);
            din   = 1'b1;
            tick();
        end
        start = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_data",  32'(data_out),   32'd0);
        check("mid_rst_valid", 32'(data_valid), 32'd0);
        check("mid_rst_busy",  32'(busy),       32'd0);
        check("mid_rst_ovr",   32'(overrun),    32'd0);
        tick();
        reset_n    = 1'b1;
        data_ready = 1'b1;
        for (int k = 0; k < 2 * FRAME; k++) begin
            din = 1'($urandom_range(0, 1));
            tick();
        end
        din = 1'b0;
        check("post_rst_valid", 32'(data_valid), 32'd0);
        check("post_rst_busy",  32'(busy),       32'd0);

        // Random words with random gaps, including back-to-back frames
        data_ready = 1'b1;
        for (int n = 0; n < 16; n++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) tick();
            w = W'($urandom_range(0, (1 << W) - 1));
            exp_q.push_back(w);
            send_frame(w);
        end
        repeat (4) tick();
        check("rand_q_empty", 32'(exp_q.size()), 32'd0);
        check("rand_overrun", 32'(overrun),      32'd0);

`ifdef RX_PARITY_EN
        // Correct parity, then wrong parity: the word is delivered both times
        data_ready = 1'b0;
        par_flip   = 1'b0;
        exp_q.push_back(8'h0F);
        send_frame(8'h0F);
        tick();
        check("par_ok", 32'(parity_err), 32'd0);
        drain();
        data_ready = 1'b0;
        par_flip   = 1'b1;
        exp_q.push_back(8'h0F);
        send_frame(8'h0F);
        tick();
        par_flip = 1'b0;
        check("par_bad",       32'(parity_err), 32'd1);
        check("par_bad_data",  32'(data_out),   32'h0F);
        check("par_bad_valid", 32'(data_valid), 32'd1);
        drain();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("par_clr", 32'(parity_err), 32'd0);
`endif

        check("final_q_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
